// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predict unit.
//   br_e     : branchE encodings (NOB, six RV32I conditions, reserved)
//   jmp_e    : jumpE encodings (none, JAL, JALR, reserved)
//   pcsrc_e  : PCSrcE encodings driven to the PC mux
//   CNT_INIT_DEF : counter value after reset (weakly not-taken)
//   br_is_cond / br_taken : condition decode helpers
package branch_pkg;

   typedef enum logic [2:0] {
      BR_NOB  = 3'b000,
      BR_BEQ  = 3'b001,
      BR_BNE  = 3'b010,
      BR_BLT  = 3'b011,
      BR_BGE  = 3'b100,
      BR_BLTU = 3'b101,
      BR_BGEU = 3'b110,
      BR_RSV  = 3'b111
   } br_e;

   typedef enum logic [1:0] {
      JMP_NONE = 2'b00,
      JMP_JAL  = 2'b01,
      JMP_JALR = 2'b10,
      JMP_RSV  = 2'b11
   } jmp_e;

   typedef enum logic [1:0] {
      PC_SEQ   = 2'b00,  // no redirect
      PC_TGT   = 2'b01,  // branch / JAL target
      PC_JALR  = 2'b10,  // JALR target
      PC_RECOV = 2'b11   // pcE+4, undo a wrong taken prediction
   } pcsrc_e;

   localparam logic [1:0] CNT_INIT_DEF = 2'b01;

   // True for the six real conditional branches (NOB and reserved excluded).
   function automatic logic br_is_cond(input logic [2:0] br);
      return (br != BR_NOB) && (br != BR_RSV);
   endfunction

   function automatic logic br_taken(input logic [2:0] br, input logic zero,
                                     input logic neg, input logic ltu);
      case (br)
         BR_BEQ:  return zero;
         BR_BNE:  return !zero;
         BR_BLT:  return neg;
         BR_BGE:  return !neg;
         BR_BLTU: return ltu;
         BR_BGEU: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline-facing bus of the branch predict unit.
//   master : pipeline side (drives fetch PC and Execute-stage fields)
//   slave  : branch_predict_unit (drives prediction, redirect, flush, stats)
interface branch_predict_unit_if #(
   parameter int STAT_W = 32
);
   logic [31:0]       pcF;
   logic              predTakenF;
   logic              validE;
   logic              stallE;
   logic [31:0]       pcE;
   logic [2:0]        branchE;
   logic [1:0]        jumpE;
   logic              predTakenE;
   logic              zero;
   logic              neg;
   logic              ltu;
   logic [1:0]        PCSrcE;
   logic              flushDE;
   logic [STAT_W-1:0] brCount;
   logic [STAT_W-1:0] mispCount;

   modport master (
      output pcF, validE, stallE, pcE, branchE, jumpE, predTakenE, zero, neg, ltu,
      input  predTakenF, PCSrcE, flushDE, brCount, mispCount
   );

   modport slave (
      input  pcF, validE, stallE, pcE, branchE, jumpE, predTakenE, zero, neg, ltu,
      output predTakenF, PCSrcE, flushDE, brCount, mispCount
   );
endinterface

// File: rtl/branch_predict_unit_bht_table.sv
// Branch history table: DEPTH x 2-bit saturating counters.
//   clk, rst_n : clock, async active-low reset (all counters -> CNT_INIT)
//   rd_pc      : fetch PC, async read of the indexed counter -> rd_cnt
//   wr_en      : apply one saturating step to counter[idx(wr_pc)]
//   wr_taken   : step direction (1 = +1, 0 = -1)
// A read of the index being written returns the old value; the new value
// shows up after the clock edge.
module branch_predict_unit_bht_table
   import branch_pkg::*;
#(
   parameter int         DEPTH    = 64,
   parameter int         IDX_LSB  = 2,
   parameter logic [1:0] CNT_INIT = CNT_INIT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] rd_pc,
   output logic [1:0]  rd_cnt,
   input  logic        wr_en,
   input  logic [31:0] wr_pc,
   input  logic        wr_taken
);
   localparam int IW = $clog2(DEPTH);

   logic [DEPTH-1:0][1:0] cnt;
   logic [IW-1:0]         rd_idx;
   logic [IW-1:0]         wr_idx;

   assign rd_idx = rd_pc[IDX_LSB +: IW];
   assign wr_idx = wr_pc[IDX_LSB +: IW];
   assign rd_cnt = cnt[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) cnt[i] <= CNT_INIT;
      end else if (wr_en) begin
         if (wr_taken && cnt[wr_idx] != 2'b11)
            cnt[wr_idx] <= cnt[wr_idx] + 2'b01;
         else if (!wr_taken && cnt[wr_idx] != 2'b00)
            cnt[wr_idx] <= cnt[wr_idx] - 2'b01;
      end
   end
endmodule

// File: rtl/branch_predict_unit.sv
// Branch controller with a 2-bit-counter predictor.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of branch_predict_unit_if
//     predTakenF          prediction for pcF (MSB of indexed counter)
//     PCSrcE / flushDE    redirect select and pipeline kill, same cycle as Execute
//     brCount / mispCount saturating counts of resolved / mispredicted branches
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int         BHT_DEPTH = 64,
   parameter int         IDX_LSB   = 2,
   parameter logic [1:0] CNT_INIT  = CNT_INIT_DEF,
   parameter int         STAT_W    = 32
) (
   input  logic clk,
   input  logic rst_n,
   branch_predict_unit_if.slave bus
);
   logic [1:0]        rd_cnt;
   logic              cond, taken, is_jump, upd, misp;
   pcsrc_e            pcsrc;
   logic [STAT_W-1:0] br_cnt, misp_cnt;

   assign cond    = br_is_cond(bus.branchE);
   assign taken   = br_taken(bus.branchE, bus.zero, bus.neg, bus.ltu);
   assign is_jump = (bus.jumpE == JMP_JAL) || (bus.jumpE == JMP_JALR);
   assign misp    = taken != bus.predTakenE;
   // Reserved jumpE=11 falls through to branch handling, so it does not block updates.
   assign upd     = bus.validE && !bus.stallE && cond && !is_jump;

   branch_predict_unit_bht_table #(
      .DEPTH   (BHT_DEPTH),
      .IDX_LSB (IDX_LSB),
      .CNT_INIT(CNT_INIT)
   ) u_bht (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_pc   (bus.pcF),
      .rd_cnt  (rd_cnt),
      .wr_en   (upd),
      .wr_pc   (bus.pcE),
      .wr_taken(taken)
   );

   assign bus.predTakenF = rd_cnt[1];

   // Redirect decode; rst_n gates it so nothing redirects while in reset.
   always_comb begin
      pcsrc = PC_SEQ;
      if (rst_n && bus.validE) begin
         case (bus.jumpE)
            JMP_JAL:  pcsrc = PC_TGT;
            JMP_JALR: pcsrc = PC_JALR;
            default: begin
               if (cond) begin
                  if (taken && !bus.predTakenE)      pcsrc = PC_TGT;
                  else if (!taken && bus.predTakenE) pcsrc = PC_RECOV;
               end
            end
         endcase
      end
   end

   assign bus.PCSrcE  = pcsrc;
   assign bus.flushDE = (pcsrc != PC_SEQ);

   // Statistics stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt   <= '0;
         misp_cnt <= '0;
      end else if (upd) begin
         if (br_cnt != '1)           br_cnt   <= br_cnt + 1'b1;
         if (misp && misp_cnt != '1) misp_cnt <= misp_cnt + 1'b1;
      end
   end

   assign bus.brCount   = br_cnt;
   assign bus.mispCount = misp_cnt;
endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
   import branch_pkg::*;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   branch_predict_unit_if #(.STAT_W(4)) bus ();

   branch_predict_unit #(
      .BHT_DEPTH(64), .IDX_LSB(2), .CNT_INIT(2'b01), .STAT_W(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one Execute slot plus fetch PC.
   task automatic ex(input logic v, input logic st, input logic [31:0] pc, input logic [2:0] br,
                     input logic [1:0] jp, input logic pe, input logic z, input logic n,
                     input logic l, input logic [31:0] pcf);
      bus.validE = v;  bus.stallE = st; bus.pcE = pc; bus.branchE = br;
      bus.jumpE = jp;  bus.predTakenE = pe; bus.zero = z; bus.neg = n; bus.ltu = l;
      bus.pcF = pcf;
   endtask

   // Advance to just after the next rising edge, then let comb settle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input logic [31:0] pcf);
      ex(1'b0, 1'b0, 32'h0, BR_NOB, JMP_NONE, 1'b0, 1'b0, 1'b0, 1'b0, pcf);
   endtask

   initial begin
      // ---- reset: outputs quiet even with a would-be redirect on the bus
      rst_n = 1'b0;
      ex(1'b1, 1'b0, 32'h40, BR_BEQ, JMP_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40);
      #3;
      chk("rst_pcsrc", bus.PCSrcE, 2'b00);
      chk("rst_flush", bus.flushDE, 1'b0);
      chk("rst_br",    bus.brCount, 4'h0);
      chk("rst_misp",  bus.mispCount, 4'h0);
      chk("rst_predF_40", bus.predTakenF, 1'b0);
      bus.pcF = 32'h1234; #1;
      chk("rst_predF_1234", bus.predTakenF, 1'b0);
      tick(); tick();
      rst_n = 1'b1;

      // ---- BEQ taken, predicted not-taken -> redirect; old counter value on read
      ex(1'b1, 1'b0, 32'h40, BR_BEQ, JMP_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40);
      #1;
      chk("beq1_pcsrc", bus.PCSrcE, 2'b01);
      chk("beq1_flush", bus.flushDE, 1'b1);
      chk("beq1_predF_rdw", bus.predTakenF, 1'b0);
      tick();
      idle(32'h40); #1;
      chk("beq1_predF_next", bus.predTakenF, 1'b1);
      chk("beq1_br",   bus.brCount, 4'd1);
      chk("beq1_misp", bus.mispCount, 4'd1);

      // ---- three more taken, now predicted taken -> no redirect, counter saturates 11
      for (int i = 0; i < 3; i++) begin
         ex(1'b1, 1'b0, 32'h40, BR_BEQ, JMP_NONE, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40);
         #1;
         chk("beq_match_pcsrc", bus.PCSrcE, 2'b00);
         tick();
      end
      idle(32'h40); #1;
      chk("beq4_br",   bus.brCount, 4'd4);
      chk("beq4_misp", bus.mispCount, 4'd1);

      // ---- not taken but predicted taken -> recovery; 11 -> 10 (still predicts taken)
      ex(1'b1, 1'b0, 32'h40, BR_BEQ, JMP_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
      #1;
      chk("beq_nt_pcsrc", bus.PCSrcE, 2'b11);
      chk("beq_nt_flush", bus.flushDE, 1'b1);
      tick();
      idle(32'h40); #1;
      chk("beq_nt_predF_10", bus.predTakenF, 1'b1);
      chk("beq_nt_misp", bus.mispCount, 4'd2);
      // second not-taken: 10 -> 01 proves the previous step landed at 10, not 11
      ex(1'b1, 1'b0, 32'h40, BR_BEQ, JMP_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
      tick();
      idle(32'h40); #1;
      chk("beq_nt2_predF_01", bus.predTakenF, 1'b0);
      chk("beq_nt2_br",   bus.brCount, 4'd6);
      chk("beq_nt2_misp", bus.mispCount, 4'd3);

      // ---- jumps override branchE; no table/stat effect
      ex(1'b1, 1'b0, 32'h40, BR_BEQ, JMP_JAL, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40);
      #1;
      chk("jal_pcsrc", bus.PCSrcE, 2'b01);
      chk("jal_flush", bus.flushDE, 1'b1);
      tick();
      // JALR with a "taken" BEQ on the bus: a wrong update would move 01 -> 10
      ex(1'b1, 1'b0, 32'h40, BR_BEQ, JMP_JALR, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40);
      #1;
      chk("jalr_pcsrc", bus.PCSrcE, 2'b10);
      tick();
      idle(32'h40); #1;
      chk("jump_predF", bus.predTakenF, 1'b0);
      chk("jump_br",    bus.brCount, 4'd6);

      // ---- bubble: taken BEQ with validE=0 does nothing
      ex(1'b0, 1'b0, 32'h40, BR_BEQ, JMP_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40);
      #1;
      chk("bubble_pcsrc", bus.PCSrcE, 2'b00);
      tick();
      idle(32'h40); #1;
      chk("bubble_predF", bus.predTakenF, 1'b0);
      chk("bubble_br",    bus.brCount, 4'd6);

      // ---- decode of remaining conditions, stalled so stats stay put
      ex(1'b1, 1'b1, 32'h40, BR_BNE, JMP_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
      #1; chk("bne_taken_match", bus.PCSrcE, 2'b00);
      ex(1'b1, 1'b1, 32'h40, BR_BLT, JMP_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40);
      #1; chk("blt_taken_pcsrc", bus.PCSrcE, 2'b01);
      ex(1'b1, 1'b1, 32'h40, BR_BGE, JMP_NONE, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40);
      #1; chk("bge_nt_pcsrc", bus.PCSrcE, 2'b11);
      ex(1'b1, 1'b1, 32'h40, BR_RSV, JMP_NONE, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
      #1; chk("rsv_pcsrc", bus.PCSrcE, 2'b00);
      ex(1'b1, 1'b1, 32'h40, BR_NOB, JMP_RSV, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
      #1; chk("nob_jrsv_pcsrc", bus.PCSrcE, 2'b00);

      // ---- BLTU not taken (ltu=0) at 0x80, stalled: no redirect, no update
      ex(1'b1, 1'b1, 32'h80, BR_BLTU, JMP_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
      #1;
      chk("bltu_stall_pcsrc", bus.PCSrcE, 2'b00);
      tick();
      idle(32'h80); #1;
      chk("bltu_stall_br", bus.brCount, 4'd6);
      // unstalled: counter 01 -> 00
      ex(1'b1, 1'b0, 32'h80, BR_BLTU, JMP_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
      tick();
      idle(32'h80); #1;
      chk("bltu_br", bus.brCount, 4'd7);
      // BGEU taken: 00 -> 01 still predicts not-taken (a skipped decrement would give 10)
      ex(1'b1, 1'b0, 32'h80, BR_BGEU, JMP_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80);
      #1;
      chk("bgeu_pcsrc", bus.PCSrcE, 2'b01);
      tick();
      idle(32'h80); #1;
      chk("bgeu_predF", bus.predTakenF, 1'b0);
      chk("bgeu_misp",  bus.mispCount, 4'd4);

      // ---- 20 mispredicted taken BEQs at 0x100: stats saturate at 4'hF
      for (int i = 0; i < 20; i++) begin
         ex(1'b1, 1'b0, 32'h100, BR_BEQ, JMP_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
         tick();
      end
      idle(32'h100); #1;
      chk("sat_br",    bus.brCount, 4'hF);
      chk("sat_misp",  bus.mispCount, 4'hF);
      chk("sat_predF", bus.predTakenF, 1'b1);

      // ---- async reset pulse mid-run clears everything immediately
      ex(1'b1, 1'b0, 32'h100, BR_BEQ, JMP_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
      rst_n = 1'b0;
      #1;
      chk("rst2_br",    bus.brCount, 4'h0);
      chk("rst2_misp",  bus.mispCount, 4'h0);
      chk("rst2_predF", bus.predTakenF, 1'b0);
      chk("rst2_pcsrc", bus.PCSrcE, 2'b00);
      chk("rst2_flush", bus.flushDE, 1'b0);
      tick();
      rst_n = 1'b1;
      #1;
      // cold start again
      chk("cold_pcsrc", bus.PCSrcE, 2'b01);
      tick();
      idle(32'h100); #1;
      chk("cold_br",    bus.brCount, 4'd1);
      chk("cold_misp",  bus.mispCount, 4'd1);
      chk("cold_predF", bus.predTakenF, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Backstop so a hung run still terminates with a report.
   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end
endmodule
